ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage RV32 pipeline; consumes the ID/EX register produced by decode.
//  Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, runs the ALU, registers EX/MEM.
//  Flags load-use hazards so decode can insert a bubble and fetch/decode can stall.
// PARAMETERS
//  D_WIDTH  32  datapath width
//  N_REGS   32  architectural registers
//  RF_SIZE  $clog2(N_REGS)  register index width
//  OP_SIZE  4   ALU op width
// PORTS
//  clk             in   1        clock
//  rst             in   1        reset: asynchronous, active-high
//  en              in   1        EX/MEM load enable (0 = hold)
//  flush           in   1        load a bubble into EX/MEM next edge
//  rs1_ex,rs2_ex   in   RF_SIZE  source indices of the instruction in EX
//  rs1_val_ex      in   D_WIDTH  RF read value, rs1
//  rs2_val_ex      in   D_WIDTH  RF read value, rs2
//  imm_ex          in   D_WIDTH  sign-extended immediate
//  rd_ex           in   RF_SIZE  destination index
//  reg_write_ex, alu_src_imm_ex, mem_we_ex, mem_re_ex, mem_to_reg_ex  in  1  control from ID/EX
//  alu_op_ex       in   OP_SIZE  ALU op
//  id_rs1,id_rs2   in   RF_SIZE  source indices of the instruction now in ID
//  wb_we           in   1        WB register write enable
//  wb_rd           in   RF_SIZE  WB destination
//  wb_data         in   D_WIDTH  WB write data
//  alu_result_mem  out  D_WIDTH  registered ALU result / memory address
//  store_data_mem  out  D_WIDTH  registered forwarded rs2 (store data)
//  rd_mem          out  RF_SIZE  registered destination
//  reg_write_mem, mem_we_mem, mem_re_mem, mem_to_reg_mem  out  1  registered control
//  load_use_stall  out  1        combinational: ID must bubble, IF/ID must hold
// BEHAVIOUR
//  - ALU ops: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed, result 0/1);
//    any other op -> result 0. Add/sub wrap modulo 2^D_WIDTH, no overflow flag.
//  - Forward A/B (per source, rsN = rs1_ex/rs2_ex):
//    1) rsN!=0 & reg_write_mem & !mem_re_mem & rd_mem==rsN -> alu_result_mem
//    2) else rsN!=0 & wb_we & wb_rd==rsN -> wb_data
//    3) else rsN_val_ex. MEM strictly beats WB when both match.
//  - Operand B = alu_src_imm_ex ? imm_ex : forwarded rs2. store_data = forwarded rs2 always.
//  - load_use_stall = mem_re_ex & rd_ex!=0 & (rd_ex==id_rs1 | rd_ex==id_rs2).
//    No suppression by opcode; false stalls on unused rs2 are accepted.
//  - EX/MEM register, priority rst > flush > en:
//    rst (async): all outputs registered to 0.
//    flush: all EX/MEM fields <= 0 (bubble: no write, no mem access).
//    en: fields <= computed values. !en & !flush: hold all fields.
//  - Latency: 1 cycle ID/EX -> EX/MEM. Forwarding paths are combinational, same cycle.
//  - While held (!en), forwarding still reads the held alu_result_mem.
//  - rd 0 never forwards. A write to x0 passes through; the RF ignores it.
//  - Reset mid-operation: in-flight instruction discarded; pipeline restarts from bubbles.
// STRUCTURE
//  - Shared package cpu_pkg: ALU op localparams (ALU_ADD..ALU_SLT, ALU_INV=4'b1111),
//    and a fwd_sel enum {FWD_RF, FWD_MEM, FWD_WB}.
//  - Sub-module alu (pure combinational: a, b, op -> y). Forward muxes, hazard detect
//    and EX/MEM register live in ex_stage.
// TESTING
//  1 add: rs1_val=5, rs2_val=7, op 0000, no hazards, en=1 -> next edge alu_result_mem=12, reg_write_mem=1.
//  2 Fwd priority: rs1_ex=3; EX/MEM holds rd=3,res=0x10; WB rd=3,data=0x20; op add, rs2_val=1 -> result 0x11.
//  3 Load-use: mem_re_ex=1, rd_ex=4, id_rs2=4 -> load_use_stall=1; rd_ex=0 -> 0; id_rs1=id_rs2=5 -> 0.
//  4 Store fwd: alu_src_imm=1, imm=-4, rs1_val=0x100, WB rd=rs2_ex=6 data=0xAB
//    -> alu_result_mem=0xFC, store_data_mem=0xAB, mem_we_mem=1.
//  5 slt signed: a=0xFFFFFFFF, b=1 -> 1; a=1, b=0xFFFFFFFF -> 0; op 1111 -> 0; sub 0-1 -> 0xFFFFFFFF.
//  6 Control: flush & en same edge -> all outputs 0; en=0 for 3 cycles -> outputs held;
//    async rst mid-cycle -> outputs 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 pipeline: ALU opcodes and forwarding-source selector.
package cpu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [OP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SLT = 4'b0101;
  localparam logic [OP_W-1:0] ALU_INV = 4'b1111;

  // Where an EX operand comes from: register file read, EX/MEM result or WB data.
  typedef enum logic [1:0] {
    FWD_RF,
    FWD_MEM,
    FWD_WB
  } fwd_sel_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage; unknown opcodes produce zero.
module alu
  import cpu_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int OP_SIZE = OP_W
) (
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  input  logic [OP_SIZE-1:0] op,
  output logic [D_WIDTH-1:0] y
);

  // NOTE: assigning y before the case gives every path a value, so no latch is inferred.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = D_WIDTH'($signed(a) < $signed(b));
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, ALU, load-use detection and the EX/MEM register.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int N_REGS  = 32,
  parameter int RF_SIZE = $clog2(N_REGS),
  parameter int OP_SIZE = OP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic [RF_SIZE-1:0] rs1_ex,
  input  logic [RF_SIZE-1:0] rs2_ex,
  input  logic [D_WIDTH-1:0] rs1_val_ex,
  input  logic [D_WIDTH-1:0] rs2_val_ex,
  input  logic [D_WIDTH-1:0] imm_ex,
  input  logic [RF_SIZE-1:0] rd_ex,
  input  logic               reg_write_ex,
  input  logic               alu_src_imm_ex,
  input  logic               mem_we_ex,
  input  logic               mem_re_ex,
  input  logic               mem_to_reg_ex,
  input  logic [OP_SIZE-1:0] alu_op_ex,
  input  logic [RF_SIZE-1:0] id_rs1,
  input  logic [RF_SIZE-1:0] id_rs2,
  input  logic               wb_we,
  input  logic [RF_SIZE-1:0] wb_rd,
  input  logic [D_WIDTH-1:0] wb_data,
  output logic [D_WIDTH-1:0] alu_result_mem,
  output logic [D_WIDTH-1:0] store_data_mem,
  output logic [RF_SIZE-1:0] rd_mem,
  output logic               reg_write_mem,
  output logic               mem_we_mem,
  output logic               mem_re_mem,
  output logic               mem_to_reg_mem,
  output logic               load_use_stall
);

  fwd_sel_t           fwd_a, fwd_b;
  logic [D_WIDTH-1:0] op_a, rs2_fwd, op_b, alu_y;

  // A load in EX/MEM has no data yet, so it is never a forwarding source;
  // the load-use stall guarantees the consumer waits for WB instead.
  always_comb begin
    fwd_a = FWD_RF;
    if (rs1_ex != '0 && reg_write_mem && !mem_re_mem && rd_mem == rs1_ex) fwd_a = FWD_MEM;
    else if (rs1_ex != '0 && wb_we && wb_rd == rs1_ex)                    fwd_a = FWD_WB;

    fwd_b = FWD_RF;
    if (rs2_ex != '0 && reg_write_mem && !mem_re_mem && rd_mem == rs2_ex) fwd_b = FWD_MEM;
    else if (rs2_ex != '0 && wb_we && wb_rd == rs2_ex)                    fwd_b = FWD_WB;
  end

  always_comb begin
    case (fwd_a)
      FWD_MEM: op_a = alu_result_mem;
      FWD_WB:  op_a = wb_data;
      default: op_a = rs1_val_ex;
    endcase
    case (fwd_b)
      FWD_MEM: rs2_fwd = alu_result_mem;
      FWD_WB:  rs2_fwd = wb_data;
      default: rs2_fwd = rs2_val_ex;
    endcase
  end

  assign op_b = alu_src_imm_ex ? imm_ex : rs2_fwd;

  alu #(
    .D_WIDTH(D_WIDTH),
    .OP_SIZE(OP_SIZE)
  ) u_alu (
    .a (op_a),
    .b (op_b),
    .op(alu_op_ex),
    .y (alu_y)
  );

  // Opcode-agnostic on purpose: a false stall on an unused rs2 only costs a cycle.
  assign load_use_stall = mem_re_ex && (rd_ex != '0) &&
                          ((rd_ex == id_rs1) || (rd_ex == id_rs2));

  // NOTE: sequential state uses non-blocking assignments so every field samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_mem <= '0;
      store_data_mem <= '0;
      rd_mem         <= '0;
      reg_write_mem  <= 1'b0;
      mem_we_mem     <= 1'b0;
      mem_re_mem     <= 1'b0;
      mem_to_reg_mem <= 1'b0;
    end else if (flush) begin
      alu_result_mem <= '0;
      store_data_mem <= '0;
      rd_mem         <= '0;
      reg_write_mem  <= 1'b0;
      mem_we_mem     <= 1'b0;
      mem_re_mem     <= 1'b0;
      mem_to_reg_mem <= 1'b0;
    end else if (en) begin
      alu_result_mem <= alu_y;
      store_data_mem <= rs2_fwd;
      rd_mem         <= rd_ex;
      reg_write_mem  <= reg_write_ex;
      mem_we_mem     <= mem_we_ex;
      mem_re_mem     <= mem_re_ex;
      mem_to_reg_mem <= mem_to_reg_ex;
    end
  end

endmodule
